fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the core.
- Owns the architectural PC and issues single-outstanding read requests to instruction memory over a req/ack plus rvalid handshake.
- Presents each fetched word downstream with a valid/ready handshake.
- Applies next-PC redirects from the branch/jump address calculator, discarding any in-flight or held fetch from the stale path.

---
 rtl/fetch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Purpose: instruction-fetch sequencer; owns the PC, issues one outstanding imem read, presents words downstream.
// Latency: REQ -> RESP -> OUT, inst_valid earliest 2 edges after the first REQ cycle; peak 1 instruction / 3 cycles.
// Backpressure: inst_ready=0 holds OUT (no new request); imem_req is held until imem_ack, never withdrawn.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   run, halt_req                start/resume in IDLE; request a stop at the next request boundary
//   imem_req/addr/ack            fetch request handshake (address stable until ack)
//   imem_rvalid/rdata            read response, at most one per accepted request
//   inst_valid/ready/pc/data     downstream instruction handshake
//   redirect_en/addr             next-PC redirect from the address calculator
//   busy, misalign_err           not-idle status; sticky misaligned-redirect flag
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  input  logic        redirect_en,
  input  logic [31:0] redirect_addr,
  output logic        busy,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        discard, discard_n;
  logic        halt_pend, halt_pend_n;
  logic        imem_req_n;
  logic [31:0] imem_addr_n;
  logic        inst_valid_n;
  logic [31:0] inst_pc_n;
  logic [31:0] inst_data_n;
  logic        busy_n;
  logic        misalign_err_n;

  logic        redir_ok;
  logic        redir_bad;
  logic        stop;
  logic        fetch_next;

  always_comb begin
    state_n        = state;
    pc_n           = pc;
    discard_n      = discard;
    imem_req_n     = imem_req;
    inst_valid_n   = inst_valid;
    inst_pc_n      = inst_pc;
    inst_data_n    = inst_data;
    fetch_next     = 1'b0;

    // Redirects only mean something while a fetch stream is active.
    redir_ok  = redirect_en && (redirect_addr[1:0] == 2'b00) && (state != IDLE);
    redir_bad = redirect_en && (redirect_addr[1:0] != 2'b00) && (state != IDLE);

    // A halt seen this cycle already counts for a boundary reached this cycle.
    stop           = halt_pend | halt_req | redir_bad;
    halt_pend_n    = stop;
    misalign_err_n = misalign_err | redir_bad;

    if (redir_ok) begin
      pc_n = redirect_addr;
    end

    case (state)
      IDLE: begin
        if (run) begin
          state_n     = REQ;
          imem_req_n  = 1'b1;
          halt_pend_n = 1'b0;
        end
      end
      REQ: begin
        // The in-flight request belongs to the stale path once redirected.
        discard_n = discard | redir_ok;
        if (imem_ack) begin
          state_n    = RESP;
          imem_req_n = 1'b0;
        end
      end
      RESP: begin
        if (imem_rvalid) begin
          if (discard || redir_ok) begin
            discard_n  = 1'b0;
            fetch_next = 1'b1;
          end else begin
            inst_valid_n = 1'b1;
            inst_pc_n    = pc;
            inst_data_n  = imem_rdata;
            state_n      = OUT;
          end
        end else begin
          discard_n = discard | redir_ok;
        end
      end
      OUT: begin
        // Redirect wins over the sequential increment, even with inst_ready.
        if (redir_ok) begin
          inst_valid_n = 1'b0;
          fetch_next   = 1'b1;
        end else if (inst_ready) begin
          pc_n         = pc + 32'd4;
          inst_valid_n = 1'b0;
          fetch_next   = 1'b1;
        end
      end
      default: begin
        state_n    = IDLE;
        imem_req_n = 1'b0;
      end
    endcase

    if (fetch_next) begin
      if (stop) begin
        state_n    = IDLE;
        imem_req_n = 1'b0;
      end else begin
        state_n    = REQ;
        imem_req_n = 1'b1;
      end
    end

    // An unacknowledged request keeps its address; otherwise track the PC.
    imem_addr_n = ((state == REQ) && !imem_ack) ? imem_addr : pc_n;
    busy_n      = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      discard      <= 1'b0;
      halt_pend    <= 1'b0;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      inst_valid   <= 1'b0;
      inst_pc      <= 32'h0;
      inst_data    <= 32'h0;
      busy         <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      discard      <= discard_n;
      halt_pend    <= halt_pend_n;
      imem_req     <= imem_req_n;
      imem_addr    <= imem_addr_n;
      inst_valid   <= inst_valid_n;
      inst_pc      <= inst_pc_n;
      inst_data    <= inst_data_n;
      busy         <= busy_n;
      misalign_err <= misalign_err_n;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Purpose: directed self-checking bench for fetch_ctrl.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: downstream stall, redirects, halts and reset mid-transaction are exercised directly.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic        halt_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        redirect_en;
  logic [31:0] redirect_addr;
  logic        busy;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .run           (run),
    .halt_req      (halt_req),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_pc       (inst_pc),
    .inst_data     (inst_data),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .busy          (busy),
    .misalign_err  (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted request: ack for one cycle.
  task automatic do_ack();
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
  endtask

  // One read response for one cycle.
  task automatic do_rvalid(input logic [31:0] d);
    imem_rvalid = 1'b1;
    imem_rdata  = d;
    tick();
    imem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_imem_addr got %h want 0", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
    checks++; if ({inst_pc, inst_data} !== 64'h0) begin errors++; $display("FAIL reset_inst got pc=%h data=%h want 0/0", inst_pc, inst_data); end
    checks++; if ({busy, misalign_err} !== 2'b00) begin errors++; $display("FAIL reset_status got busy=%b mis=%b want 0/0", busy, misalign_err); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic_fetch();
    run = 1'b1;
    tick();
    run = 1'b0;
    checks++; if ({imem_req, busy} !== 2'b11 || imem_addr !== 32'h0) begin errors++; $display("FAIL basic_req0 got req=%b busy=%b addr=%h want 1/1/0", imem_req, busy, imem_addr); end
    do_ack();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_resp_req got %b want 0", imem_req); end
    do_rvalid(32'h0000_0013);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h0000_0013) begin errors++; $display("FAIL basic_inst0 got v=%b pc=%h d=%h want 1/0/00000013", inst_valid, inst_pc, inst_data); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || inst_valid !== 1'b0) begin errors++; $display("FAIL basic_req4 got req=%b addr=%h v=%b want 1/4/0", imem_req, imem_addr, inst_valid); end
  endtask

  task automatic test_stall();
    do_ack();
    do_rvalid(32'h0010_0093);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst_data !== 32'h0010_0093 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b pc=%h d=%h req=%b want 1/4/00100093/0", i, inst_valid, inst_pc, inst_data, imem_req);
      end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL stall_next got req=%b addr=%h want 1/8", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_at_ack();
    redirect_en   = 1'b1;
    redirect_addr = 32'h100;
    do_ack();
    redirect_en = 1'b0;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin errors++; $display("FAIL rdack_resp got req=%b addr=%h want 0/100", imem_req, imem_addr); end
    do_rvalid(32'hDEAD_BEEF);
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rdack_drop got v=%b req=%b addr=%h want 0/1/100", inst_valid, imem_req, imem_addr); end
    do_ack();
    do_rvalid(32'h0000_0011);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== 32'h11) begin errors++; $display("FAIL rdack_inst got v=%b pc=%h d=%h want 1/100/11", inst_valid, inst_pc, inst_data); end
  endtask

  task automatic test_redirect_in_out();
    inst_ready    = 1'b1;
    redirect_en   = 1'b1;
    redirect_addr = 32'h200;
    tick();
    inst_ready  = 1'b0;
    redirect_en = 1'b0;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rdout_req got v=%b req=%b addr=%h want 0/1/200", inst_valid, imem_req, imem_addr); end
    do_ack();
    do_rvalid(32'h0000_0022);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst_data !== 32'h22) begin errors++; $display("FAIL rdout_inst got v=%b pc=%h d=%h want 1/200/22", inst_valid, inst_pc, inst_data); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin errors++; $display("FAIL rdout_next got req=%b addr=%h want 1/204", imem_req, imem_addr); end
  endtask

  task automatic test_misalign();
    redirect_en   = 1'b1;
    redirect_addr = 32'h102;
    tick();
    redirect_en = 1'b0;
    checks++; if (misalign_err !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h204) begin errors++; $display("FAIL mis_flag got mis=%b req=%b addr=%h want 1/1/204", misalign_err, imem_req, imem_addr); end
    do_ack();
    do_rvalid(32'h0000_0033);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h204 || inst_data !== 32'h33) begin errors++; $display("FAIL mis_inst got v=%b pc=%h d=%h want 1/204/33", inst_valid, inst_pc, inst_data); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL mis_idle got busy=%b req=%b v=%b want 0/0/0", busy, imem_req, inst_valid); end
    run = 1'b1;
    tick();
    run = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h208 || misalign_err !== 1'b1) begin errors++; $display("FAIL mis_resume got req=%b addr=%h mis=%b want 1/208/1", imem_req, imem_addr, misalign_err); end
  endtask

  task automatic test_wrap_halt();
    redirect_en   = 1'b1;
    redirect_addr = 32'hFFFF_FFFC;
    tick();
    redirect_en = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h208) begin errors++; $display("FAIL wrap_hold got req=%b addr=%h want 1/208", imem_req, imem_addr); end
    do_ack();
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_resp got req=%b addr=%h want 0/fffffffc", imem_req, imem_addr); end
    do_rvalid(32'h0000_0BAD);
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_drop got v=%b req=%b addr=%h want 0/1/fffffffc", inst_valid, imem_req, imem_addr); end
    do_ack();
    halt_req = 1'b1;
    do_rvalid(32'h0000_0044);
    halt_req = 1'b0;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst_data !== 32'h44) begin errors++; $display("FAIL wrap_inst got v=%b pc=%h d=%h want 1/fffffffc/44", inst_valid, inst_pc, inst_data); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks++; if (busy !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_halt got busy=%b req=%b addr=%h want 0/0/0", busy, imem_req, imem_addr); end
    run = 1'b1;
    tick();
    run = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_resume got req=%b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_reset_in_flight();
    do_ack();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || busy !== 1'b0 || misalign_err !== 1'b0) begin errors++; $display("FAIL rst_fl got req=%b addr=%h busy=%b mis=%b want 0/0/0/0", imem_req, imem_addr, busy, misalign_err); end
    checks++; if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst_data !== 32'h0) begin errors++; $display("FAIL rst_fl_inst got v=%b pc=%h d=%h want 0/0/0", inst_valid, inst_pc, inst_data); end
    do_rvalid(32'h0000_0055);
    tick();
    checks++; if (inst_valid !== 1'b0 || busy !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rst_late_rvalid got v=%b busy=%b req=%b want 0/0/0", inst_valid, busy, imem_req); end
  endtask

  initial begin
    reset_n       = 1'b0;
    run           = 1'b0;
    halt_req      = 1'b0;
    imem_ack      = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    inst_ready    = 1'b0;
    redirect_en   = 1'b0;
    redirect_addr = 32'h0;

    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_at_ack();
    test_redirect_in_out();
    test_misalign();
    test_wrap_halt();
    test_reset_in_flight();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
